// File: rtl/usart_rx.sv
`timescale 1ns/1ps
// usart_rx: receives start, DATA_LENGTH data bits (LSB first), parity and stop, then offers the word on valid/ready.
// Optional stop-bit check with a framing_error output is built when USART_RX_FRAMING_CHECK_EN is defined.
module usart_rx #(
  parameter int DATA_LENGTH  = 48,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sig,
  output logic [DATA_LENGTH-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   parity_error,
  output logic                   overrun
`ifdef USART_RX_FRAMING_CHECK_EN
  ,
  output logic                   framing_error
`endif
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_LENGTH);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic                   sig_m;
  logic                   sig_s;
  logic                   sig_prev;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_LENGTH-1:0] shift_reg;
  logic                   parity_bit;
  logic                   bit_centre;
  logic                   frame_done;
  logic                   frame_keep;
  logic                   frame_parity_error;

  assign bit_centre         = (baud_cnt == BAUD_FULL);
  assign frame_done         = (state == STOP) && bit_centre;
  assign frame_parity_error = ((^shift_reg) ^ parity_bit) != PARITY_ODD[0];

`ifdef USART_RX_FRAMING_CHECK_EN
  assign frame_keep = sig_s;
`else
  assign frame_keep = 1'b1;
`endif

  // Two-flop synchronizer; flops idle high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_m    <= 1'b1;
      sig_s    <= 1'b1;
      sig_prev <= 1'b1;
    end else begin
      sig_m    <= sig;
      sig_s    <= sig_m;
      sig_prev <= sig_s;
    end
  end

  // Handshake: a word is transferred on every cycle with valid && ready. While valid is
  // high, data and parity_error stay stable. A frame completing while valid && !ready
  // is dropped and flagged by a one-cycle overrun pulse; one completing in the same
  // cycle as a transfer replaces the word and keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      data         <= '0;
      valid        <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
`ifdef USART_RX_FRAMING_CHECK_EN
      framing_error <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
`ifdef USART_RX_FRAMING_CHECK_EN
      framing_error <= 1'b0;
`endif
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sig_prev && !sig_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_HALF) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= sig_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_centre) begin
            baud_cnt  <= '0;
            shift_reg <= {sig_s, shift_reg[DATA_LENGTH-1:1]};
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_centre) begin
            baud_cnt   <= '0;
            parity_bit <= sig_s;
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_centre) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (frame_done) begin
        if (frame_keep) begin
          if (!valid || ready) begin
            data         <= shift_reg;
            parity_error <= frame_parity_error;
            valid        <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
`ifdef USART_RX_FRAMING_CHECK_EN
        else begin
          framing_error <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_usart_rx.sv
`timescale 1ns/1ps
// tb_usart_rx: directed frames into usart_rx with hand-computed payloads, parity and timing.
module tb_usart_rx;

  localparam int DL  = 48;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          sig;
  logic          ready;
  logic [DL-1:0] data;
  logic          valid;
  logic          parity_error;
  logic          overrun;
`ifdef USART_RX_FRAMING_CHECK_EN
  logic          framing_error;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [DL-1:0] exp_q[$];

  logic          v_pre, v_at, v_next, pe_at, ov_at, ov_next, fe_at;
  logic [DL-1:0] d_at;
  logic          valid_seen;
  logic [DL-1:0] partial;

  always #5 clk = ~clk;

  usart_rx #(
    .DATA_LENGTH (DL),
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sig         (sig),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .parity_error(parity_error),
    .overrun     (overrun)
`ifdef USART_RX_FRAMING_CHECK_EN
    ,
    .framing_error(framing_error)
`endif
  );

  task automatic check(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag);
    logic [DL-1:0] e;
    e = exp_q.pop_front();
    check(tag, d_at, e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    sig = b;
    wait_cycles(CPB);
  endtask

  // Stop-bit centre is sampled 11 edges after the stop bit is driven (2 sync + 9 counts);
  // valid is therefore visible at k==10 and not yet at k==9.
  task automatic send_frame(input logic [DL-1:0] d, input logic par, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < DL; i++) drive_bit(d[i]);
    drive_bit(par);
    sig = stp;
    for (int k = 0; k < CPB; k++) begin
      @(posedge clk);
      #1;
      if (k == 9) v_pre = valid;
      if (k == 10) begin
        v_at  = valid;
        d_at  = data;
        pe_at = parity_error;
        ov_at = overrun;
`ifdef USART_RX_FRAMING_CHECK_EN
        fe_at = framing_error;
`else
        fe_at = 1'b0;
`endif
      end
      if (k == 11) begin
        v_next  = valid;
        ov_next = overrun;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sig   = 1'b1;
    ready = 1'b1;
    wait_cycles(3);
    check("rst_valid", {47'd0, valid}, 48'd0);
    check("rst_data", data, 48'd0);
    check("rst_perr", {47'd0, parity_error}, 48'd0);
    check("rst_overrun", {47'd0, overrun}, 48'd0);
    check("rst_state", 48'(dut.state), 48'd0);
    reset = 1'b0;
    wait_cycles(20);

    // Good frame, even parity bit 1 (payload has 21 ones).
    exp_q.push_back(48'hA5A5_0F0F_1234);
    send_frame(48'hA5A5_0F0F_1234, 1'b1, 1'b1);
    check("t1_valid_early", {47'd0, v_pre}, 48'd0);
    check("t1_valid", {47'd0, v_at}, 48'd1);
    check_data("t1_data");
    check("t1_perr", {47'd0, pe_at}, 48'd0);
    check("t1_overrun", {47'd0, ov_at}, 48'd0);
    check("t1_valid_drop", {47'd0, v_next}, 48'd0);

    // Same payload, wrong parity bit.
    exp_q.push_back(48'hA5A5_0F0F_1234);
    send_frame(48'hA5A5_0F0F_1234, 1'b0, 1'b1);
    check("t2_valid", {47'd0, v_at}, 48'd1);
    check_data("t2_data");
    check("t2_perr", {47'd0, pe_at}, 48'd1);

    // Start glitch of 4 cycles must be rejected at mid start bit.
    valid_seen = 1'b0;
    sig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cycles(1);
      valid_seen |= valid;
    end
    sig = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wait_cycles(1);
      valid_seen |= valid;
    end
    check("glitch_valid", {47'd0, valid_seen}, 48'd0);
    check("glitch_state", 48'(dut.state), 48'd0);
    exp_q.push_back(48'h1);
    send_frame(48'h1, 1'b1, 1'b1);
    check("t3_valid", {47'd0, v_at}, 48'd1);
    check_data("t3_data");
    check("t3_perr", {47'd0, pe_at}, 48'd0);

    // Overrun: consumer stalled across two back-to-back frames.
    ready = 1'b0;
    exp_q.push_back(48'h11);
    send_frame(48'h11, 1'b0, 1'b1);
    check("t4_valid1", {47'd0, v_at}, 48'd1);
    check_data("t4_data1");
    check("t4_overrun1", {47'd0, ov_at}, 48'd0);
    send_frame(48'h22, 1'b0, 1'b1);
    check("t4_valid2", {47'd0, v_at}, 48'd1);
    check("t4_data_kept", d_at, 48'h11);
    check("t4_overrun_pulse", {47'd0, ov_at}, 48'd1);
    check("t4_overrun_end", {47'd0, ov_next}, 48'd0);
    ready = 1'b1;
    wait_cycles(1);
    check("t4_valid_drop", {47'd0, valid}, 48'd0);

    // Reset during data bit 20; the partial frame must vanish.
    partial = 48'h0F0F_0F0F_0F0F;
    drive_bit(1'b0);
    for (int i = 0; i < 20; i++) drive_bit(partial[i]);
    sig = partial[20];
    wait_cycles(8);
    reset = 1'b1;
    sig   = 1'b1;
    wait_cycles(1);
    check("t5_valid", {47'd0, valid}, 48'd0);
    check("t5_data", data, 48'd0);
    check("t5_perr", {47'd0, parity_error}, 48'd0);
    check("t5_overrun", {47'd0, overrun}, 48'd0);
    check("t5_state", 48'(dut.state), 48'd0);
    reset = 1'b0;
    wait_cycles(40);
    exp_q.push_back(48'hFFFF_FFFF_FFFF);
    send_frame(48'hFFFF_FFFF_FFFF, 1'b0, 1'b1);
    check("t5_rx_valid", {47'd0, v_at}, 48'd1);
    check_data("t5_rx_data");
    check("t5_rx_perr", {47'd0, pe_at}, 48'd0);

    // Stop bit held low.
`ifdef USART_RX_FRAMING_CHECK_EN
    send_frame(48'hC3, 1'b0, 1'b0);
    check("t6_framing", {47'd0, fe_at}, 48'd1);
    check("t6_no_valid", {47'd0, v_at}, 48'd0);
    check("t6_framing_end", {47'd0, v_next}, 48'd0);
`else
    exp_q.push_back(48'hC3);
    send_frame(48'hC3, 1'b0, 1'b0);
    check("t6_valid", {47'd0, v_at}, 48'd1);
    check_data("t6_data");
    check("t6_perr", {47'd0, pe_at}, 48'd0);
    check("t6_no_framing", {47'd0, fe_at}, 48'd0);
`endif
    sig = 1'b1;
    wait_cycles(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- Serial receiver that drives the rx side of the USART link: it samples the incoming serial line, deserializes one DATA_LENGTH-bit frame and checks its parity.
- Presents the result as a valid/ready word to the UsartManager.
- Sits directly downstream of the USART transmitter on the same link and produces everything the rx_reader consumes.

Parameters:
- DATA_LENGTH, 48, payload bits per frame (must be >= 2).
- CLKS_PER_BIT, 16, clk cycles per serial bit (even, >= 4).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sig  in  1  serial line; idles high; asynchronous to clk.
- data  out  DATA_LENGTH  received payload.
- valid  out  1  data/parity_error hold a new frame.
- ready  in  1  consumer accepts the word when high with valid.
- parity_error  out  1  parity mismatch for the word in data.
- overrun  out  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Frame format, in order:
  - start bit 0
  - DATA_LENGTH data bits, LSB first
  - one parity bit
  - stop bit 1
- Line synchronisation: sig passes through a 2-flop synchronizer, whose flops reset to 1. All decisions use the synchronized value sig_s.
- Reset values: data=0, valid=0, parity_error=0, overrun=0, state=IDLE, all counters 0.
- Reset mid-frame: the partial frame is discarded, and reception restarts only on the next falling edge seen after reset.
- Counters:
  - baud counter is $clog2(CLKS_PER_BIT) bits wide.
  - bit index is $clog2(DATA_LENGTH) bits wide.
  - shift register is DATA_LENGTH bits; bits enter at the MSB and shift right.
- State machine:
  - IDLE: falling edge on sig_s (previous 1, current 0) -> START, baud counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample sig_s.
    - sig_s=1: glitch -> IDLE, nothing reported.
    - sig_s=0: -> DATA, counter cleared.
  - DATA: sample at count CLKS_PER_BIT-1, i.e. every CLKS_PER_BIT cycles, at bit centres. After bit index DATA_LENGTH-1 -> PARITY.
  - PARITY: sample the parity bit at bit centre -> STOP.
  - STOP: sample the stop bit at bit centre.
    - Completion event fires on this cycle, then -> IDLE.
    - A new start edge is accepted from the next cycle (second half of the stop bit).
- Parity rule: parity_error = (^payload ^ parity_bit) != PARITY_ODD.
- Latency: valid rises exactly 1 cycle after the stop-bit sample cycle.
- Output on completion: data and parity_error are registered in that same cycle.
- Handshake:
  - valid stays high, with data and parity_error held stable, until a cycle with valid&&ready.
  - valid falls on the following cycle unless a new word is loaded in that same cycle.
  - ready while valid=0 has no effect.
- Completion while valid=1 and ready=0 (overrun):
  - new frame dropped;
  - old word kept;
  - overrun pulses 1 cycle.
- Completion in the same cycle as valid&&ready: the new word is loaded, valid stays 1, no overrun.
- sig held low forever: one start, then a frame that ends in STOP; stop-bit handling per the Optional Feature. No new start is accepted until sig_s returns high and falls again.

Optional Feature:
- Macro: USART_RX_FRAMING_CHECK_EN.
- Defined:
  - STOP samples sig_s; if 0, the frame is discarded (no valid, no overrun).
  - An extra output framing_error (out, 1) pulses 1 cycle.
  - framing_error resets to 0.
- Undefined:
  - the stop-bit value is ignored, every completed frame is reported;
  - the framing_error port does not exist.

Test Plan (DATA_LENGTH=48, CLKS_PER_BIT=16, PARITY_ODD=0):
- Send 48'hA5A5_0F0F_1234 with correct even parity bit 1, ready=1 -> valid for 1 cycle, data=48'hA5A5_0F0F_1234, parity_error=0, valid 1 cycle after the stop-bit centre.
- Same payload with parity bit 0 -> valid, data=48'hA5A5_0F0F_1234, parity_error=1.
- Drive sig low 4 cycles then high -> state returns to IDLE, valid never asserts; a following good frame 48'h1 (parity 1) is received correctly.
- ready=0; send 48'h11 then 48'h22 back-to-back -> data stays 48'h11, overrun pulses once at the second stop sample; raise ready -> valid drops next cycle.
- Assert reset for 1 cycle mid-DATA (bit 20) -> all outputs 0 next cycle, no valid; the next full frame 48'hFFFF_FFFF_FFFF (parity 0) is received.
- With USART_RX_FRAMING_CHECK_EN: frame with stop bit 0 -> framing_error pulse, no valid. Without the macro: same stimulus -> valid with the payload.
